master_arbiter_ctrl: RTL and testbench
======================================

# master_arbiter_ctrl

Master-side controller for the serial arbitration link. It sits between one bus master core and its dedicated arbiter line pair. It serialises the master's control frames (request, ack/start, over, hold) onto `port_in`, decodes arbiter frames (grant, preempt) from `port_out`, and tells the master core when it owns the shared bus. One instance exists per master; the arbiter drives the multiplexer selects from these frames.

## Interface
- `S_ID_WIDTH`, default 2: width of the slave ID carried in a request frame (2 bits = 3 slaves + "none").
- `clk` input, 1: system clock; all logic on rising edge.
- `rstN` input, 1: asynchronous, active-low reset.
- `req` input, 1: master core requests the bus; sampled only in IDLE.
- `slave_id` input, S_ID_WIDTH: target slave; captured with `req`.
- `end_com` input, 1: master finished its transfer; sampled only in COMM.
- `split` input, 1: master wants to release the bus temporarily (slow slave); sampled only in COMM.
- `port_out` input, 1: serial line from arbiter to this master.
- `port_in` output, 1: serial line from this master to arbiter; registered.
- `bus_granted` output, 1: high while in COMM; registered.
- `suspended` output, 1: high in SUSPENDED; registered.
- `preempted` output, 1: one-cycle pulse when a hold is caused by an arbiter preempt.
- `busy` output, 1: high in every state except IDLE.

## Operation
- TX FSM states: IDLE, REQ_TX, WAIT_GRANT, ACK_TX, COMM, OVER_TX, HOLD_TX, SUSPENDED.
- IDLE: `port_in`=0. `req`=1 latches `slave_id` and enters REQ_TX.
- REQ_TX: 6 bits, one per cycle: 1,1,1,id[1],id[0],0 (MSB first). Then WAIT_GRANT.
- WAIT_GRANT: `port_in`=0. A detected grant enters ACK_TX.
- ACK_TX: 3 bits: 1,0,1. Then COMM.
- COMM: `port_in` held at 1 and `bus_granted`=1.
  - `end_com` enters OVER_TX.
  - `split`, or a pending preempt, enters HOLD_TX.
- OVER_TX: 4 bits: 0,1,1,0. Then IDLE.
- HOLD_TX: 4 bits: 0,1,0,0. Then SUSPENDED.
- SUSPENDED: `port_in`=0. A detected grant enters ACK_TX; the same slave_id is kept and no new request frame is sent.
- RX decoder (runs in parallel):
  - Idle while `port_out`=0.
  - A 1 is a start bit; the next 2 bits are the code.
  - Code 11 produces a grant pulse; code 10 produces a preempt pulse; 00 and 01 are discarded.
  - After the second code bit the decoder returns to idle, so the next 1 starts a new frame.
- Grant pulses are honoured only in WAIT_GRANT and SUSPENDED; all other states ignore them.
- Preempt pulses:
  - Honoured in ACK_TX and COMM; otherwise ignored.
  - In ACK_TX the preempt is latched as pending and acted on in the first COMM cycle.
  - `preempted` pulses in the cycle HOLD_TX is entered due to a preempt.
- Priority in COMM: `end_com` > `split` > pending preempt.
  - `end_com` clears any pending preempt.
  - `split` together with a preempt gives one hold; `preempted` still pulses.
- Bit counter: 3 bits, cleared on every frame-state entry; a frame ends when it reaches length−1.

## Timing
- Reset values: `port_in`=0, `bus_granted`=0, `suspended`=0, `preempted`=0, `busy`=0; TX FSM=IDLE, RX decoder=idle, pending preempt=0.
- Reset is asynchronous: asserting `rstN` mid-frame forces all outputs to reset values immediately; the partial frame is abandoned.
- Cycle 0 = `req` sampled high in IDLE. `port_in` shows the first request bit in cycle 1 and the trailing 0 in cycle 6. WAIT_GRANT starts in cycle 7.
- Grant latency: grant pulse asserts the cycle after the last code bit is sampled. ACK_TX's first bit (1) drives `port_in` the next cycle.
- `bus_granted` rises in the cycle after the last ACK bit and falls in the first OVER_TX or HOLD_TX cycle.
- `req` in any non-IDLE state is ignored. `end_com` and `split` outside COMM are ignored.
- `busy` is combinational from state; all other outputs are registered.

## Test plan
- Basic transfer: `req`=1, `slave_id`=2'b10 → `port_in` 1,1,1,1,0,0. Drive `port_out` 1,1,1 → `port_in` 1,0,1, then `bus_granted`=1. Pulse `end_com` → `port_in` 0,1,1,0, `busy`=0.
- Preempt: in COMM, drive `port_out` 1,1,0 → `preempted` pulse, `port_in` 0,1,0,0, `suspended`=1. Regrant with 1,1,1 → ACK 1,0,1 with no new request frame, then `bus_granted`=1.
- Split: `split` pulse in COMM → hold frame, SUSPENDED. Regrant → COMM. `end_com` → OVER, IDLE.
- Simultaneous events: `end_com`+`split` in the same cycle → OVER frame only. Preempt during ACK_TX → HOLD_TX entered one cycle after COMM entry.
- Ignored inputs: grant frame during REQ_TX, preempt in WAIT_GRANT, code 01, `req` in COMM → no state change.
- Reset mid-REQ_TX (bit 3): `port_in`=0 immediately. After release, a new `req` restarts the full 6-bit frame.

Source files
------------

// File: rtl/master_arbiter_ctrl_if.sv
// rtl/master_arbiter_ctrl_if.sv - master core and arbiter line signals of one master controller
interface master_arbiter_ctrl_if #(
  parameter int S_ID_WIDTH = 2
);
  logic                  req;
  logic [S_ID_WIDTH-1:0] slave_id;
  logic                  end_com;
  logic                  split;
  logic                  port_out;
  logic                  port_in;
  logic                  bus_granted;
  logic                  suspended;
  logic                  preempted;
  logic                  busy;

  modport master (
    output req, slave_id, end_com, split, port_out,
    input  port_in, bus_granted, suspended, preempted, busy
  );

  modport slave (
    input  req, slave_id, end_com, split, port_out,
    output port_in, bus_granted, suspended, preempted, busy
  );
endinterface

// File: rtl/master_arbiter_ctrl.sv
// rtl/master_arbiter_ctrl.sv - serialises master control frames and decodes arbiter grant/preempt frames
module master_arbiter_ctrl #(
  parameter int S_ID_WIDTH = 2
) (
  input  logic                clk,
  input  logic                rstN,
  master_arbiter_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_REQ_TX, S_WAIT_GRANT, S_ACK_TX,
    S_COMM, S_OVER_TX, S_HOLD_TX, S_SUSPENDED
  } state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_CODE1, RX_CODE2} rx_state_t;

  state_t                state, state_d;
  rx_state_t             rx_state;
  logic [2:0]            cnt, cnt_d;
  logic                  pend, pend_d;
  logic                  hold_by_preempt;
  logic                  port_in_d;
  logic                  code_hi;
  logic                  grant_p, preempt_p;
  logic [S_ID_WIDTH-1:0] id_q;

  // Arbiter frame: start bit, then two code bits; pulses appear the cycle after the last code bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rx_state  <= RX_IDLE;
      code_hi   <= 1'b0;
      grant_p   <= 1'b0;
      preempt_p <= 1'b0;
    end else begin
      grant_p   <= 1'b0;
      preempt_p <= 1'b0;
      case (rx_state)
        RX_IDLE:  if (bus.port_out) rx_state <= RX_CODE1;
        RX_CODE1: begin
          code_hi  <= bus.port_out;
          rx_state <= RX_CODE2;
        end
        RX_CODE2: begin
          grant_p   <= code_hi & bus.port_out;
          preempt_p <= code_hi & ~bus.port_out;
          rx_state  <= RX_IDLE;
        end
        default:  rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    state_d         = state;
    pend_d          = pend;
    hold_by_preempt = 1'b0;
    case (state)
      S_IDLE:       if (bus.req) state_d = S_REQ_TX;
      S_REQ_TX:     if (cnt == 3'd5) state_d = S_WAIT_GRANT;
      S_WAIT_GRANT: if (grant_p) state_d = S_ACK_TX;
      S_SUSPENDED:  if (grant_p) state_d = S_ACK_TX;
      S_ACK_TX: begin
        if (preempt_p) pend_d = 1'b1;
        if (cnt == 3'd2) state_d = S_COMM;
      end
      S_COMM: begin
        if (bus.end_com) begin
          state_d = S_OVER_TX;
          pend_d  = 1'b0;
        end else if (bus.split || pend || preempt_p) begin
          state_d         = S_HOLD_TX;
          hold_by_preempt = pend | preempt_p;
          pend_d          = 1'b0;
        end
      end
      S_OVER_TX:    if (cnt == 3'd3) state_d = S_IDLE;
      S_HOLD_TX:    if (cnt == 3'd3) state_d = S_SUSPENDED;
      default:      state_d = S_IDLE;
    endcase

    cnt_d = (state_d == state) ? cnt + 3'd1 : 3'd0;

    // port_in is registered, so the line level is derived from the state/bit being entered.
    case (state_d)
      S_REQ_TX:  port_in_d = (cnt_d == 3'd3) ? id_q[1] :
                             (cnt_d == 3'd4) ? id_q[0] : (cnt_d != 3'd5);
      S_ACK_TX:  port_in_d = (cnt_d != 3'd1);
      S_COMM:    port_in_d = 1'b1;
      S_OVER_TX: port_in_d = (cnt_d == 3'd1) || (cnt_d == 3'd2);
      S_HOLD_TX: port_in_d = (cnt_d == 3'd1);
      default:   port_in_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state           <= S_IDLE;
      cnt             <= 3'd0;
      pend            <= 1'b0;
      id_q            <= '0;
      bus.port_in     <= 1'b0;
      bus.bus_granted <= 1'b0;
      bus.suspended   <= 1'b0;
      bus.preempted   <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      pend            <= pend_d;
      if (state == S_IDLE && bus.req) id_q <= bus.slave_id;
      bus.port_in     <= port_in_d;
      bus.bus_granted <= (state_d == S_COMM);
      bus.suspended   <= (state_d == S_SUSPENDED);
      bus.preempted   <= hold_by_preempt;
    end
  end

  assign bus.busy = (state != S_IDLE);
endmodule

// File: tb/tb_master_arbiter_ctrl.sv
// tb/tb_master_arbiter_ctrl.sv - scoreboard bench for master_arbiter_ctrl against a frame-queue model
module tb_master_arbiter_ctrl;
  logic clk;
  logic rstN;

  master_arbiter_ctrl_if #(.S_ID_WIDTH(2)) bus ();

  master_arbiter_ctrl #(.S_ID_WIDTH(2)) dut (
    .clk  (clk),
    .rstN (rstN),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef enum int {PH_IDLE, PH_REQ, PH_WAIT, PH_ACK, PH_COMM, PH_OVER, PH_HOLD, PH_SUSP} ph_t;
  typedef enum int {EV_NONE, EV_GRANT, EV_PRE} ev_t;

  typedef struct {
    bit port_in;
    bit granted;
    bit susp;
    bit pre;
    bit busy;
  } exp_t;

  typedef struct {
    bit  b;
    ev_t ev;
  } rx_bit_t;

  exp_t    exp_q[$];
  rx_bit_t rx_q[$];
  bit      frame_q[$];
  ph_t     ph;
  bit      pend;
  bit      exp_pre;
  bit [1:0] mid;
  ev_t     ev_cur, ev_next;
  int      n_cmp = 0;
  int      n_fail = 0;

  function automatic void chk(string name, logic act, bit req_v);
    n_cmp++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req_v);
    end
  endfunction

  function automatic exp_t expected();
    exp_t e;
    e.port_in = (frame_q.size() > 0) ? frame_q[0] : (ph == PH_COMM);
    e.granted = (ph == PH_COMM);
    e.susp    = (ph == PH_SUSP);
    e.pre     = exp_pre;
    e.busy    = (ph != PH_IDLE);
    return e;
  endfunction

  task automatic load(input bit [7:0] v, input int len);
    frame_q.delete();
    for (int i = len - 1; i >= 0; i--) frame_q.push_back(v[i]);
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    pend = 1'b0;
    exp_pre = 1'b0;
    frame_q.delete();
    ev_cur = EV_NONE;
    ev_next = EV_NONE;
  endtask

  // Frame states simply drain their bit queue; the follow-on phase is taken when it empties.
  task automatic model_edge();
    bit tmp;
    case (ph)
      PH_IDLE: if (bus.req) begin
        mid = bus.slave_id;
        ph = PH_REQ;
        load({2'b00, 3'b111, mid, 1'b0}, 6);
      end
      PH_REQ, PH_ACK, PH_OVER, PH_HOLD: begin
        if (ph == PH_ACK && ev_cur == EV_PRE) pend = 1'b1;
        tmp = frame_q.pop_front();
        if (frame_q.size() == 0) begin
          case (ph)
            PH_REQ:  ph = PH_WAIT;
            PH_ACK:  ph = PH_COMM;
            PH_OVER: ph = PH_IDLE;
            default: ph = PH_SUSP;
          endcase
        end
      end
      PH_WAIT, PH_SUSP: if (ev_cur == EV_GRANT) begin
        ph = PH_ACK;
        load(8'b101, 3);
      end
      PH_COMM: begin
        if (bus.end_com) begin
          ph = PH_OVER;
          load(8'b0110, 4);
          pend = 1'b0;
        end else if (bus.split || pend || ev_cur == EV_PRE) begin
          ph = PH_HOLD;
          load(8'b0100, 4);
          exp_pre = pend || (ev_cur == EV_PRE);
          pend = 1'b0;
        end
      end
      default: ph = PH_IDLE;
    endcase
  endtask

  task automatic step();
    rx_bit_t rb;
    @(posedge clk);
    exp_pre = 1'b0;
    if (rstN) model_edge();
    exp_q.push_back(expected());
    #1;
    ev_cur = ev_next;
    ev_next = EV_NONE;
    if (rx_q.size() > 0) begin
      rb = rx_q.pop_front();
      bus.port_out = rb.b;
      ev_next = rb.ev;
    end else begin
      bus.port_out = 1'b0;
    end
  endtask

  task automatic send_frame(input bit [1:0] code);
    rx_bit_t rb;
    rb.b = 1'b1;     rb.ev = EV_NONE; rx_q.push_back(rb);
    rb.b = code[1];  rx_q.push_back(rb);
    rb.b = code[0];
    rb.ev = (code == 2'b11) ? EV_GRANT : (code == 2'b10) ? EV_PRE : EV_NONE;
    rx_q.push_back(rb);
  endtask

  task automatic cyc(input bit r, input bit [1:0] id, input bit e, input bit s);
    bus.req = r;
    bus.slave_id = id;
    bus.end_com = e;
    bus.split = s;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'b00, 1'b0, 1'b0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must drop before the next edge.
  task automatic reset_mid();
    #2;
    rstN = 1'b0;
    model_reset();
    exp_q.delete();
    rx_q.delete();
    bus.req = 1'b0; bus.end_com = 1'b0; bus.split = 1'b0; bus.port_out = 1'b0;
    exp_q.push_back(expected());
    #1;
    chk("async_rst_port_in", bus.port_in, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_granted", bus.bus_granted, 1'b0);
    step();
    step();
    rstN = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("port_in", bus.port_in, e.port_in);
        chk("bus_granted", bus.bus_granted, e.granted);
        chk("suspended", bus.suspended, e.susp);
        chk("preempted", bus.preempted, e.pre);
        chk("busy", bus.busy, e.busy);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin : driver
    rstN = 1'b0;
    bus.req = 1'b0; bus.slave_id = 2'b00; bus.end_com = 1'b0;
    bus.split = 1'b0; bus.port_out = 1'b0;
    model_reset();
    step(); step(); step();
    rstN = 1'b1;

    // basic transfer to slave 2
    cyc(1'b1, 2'b10, 1'b0, 1'b0); idle(7);
    send_frame(2'b11); idle(9);
    cyc(1'b0, 2'b00, 1'b1, 1'b0); idle(6);
    // preempt in COMM, then regrant without new request
    cyc(1'b1, 2'b01, 1'b0, 1'b0); idle(7);
    send_frame(2'b11); idle(9);
    send_frame(2'b10); idle(10);
    send_frame(2'b11); idle(10);
    cyc(1'b0, 2'b00, 1'b1, 1'b0); idle(6);
    // split, regrant, end_com+split together
    cyc(1'b1, 2'b11, 1'b0, 1'b0); idle(7);
    send_frame(2'b11); idle(9);
    cyc(1'b0, 2'b00, 1'b0, 1'b1); idle(6);
    send_frame(2'b11); idle(9);
    cyc(1'b0, 2'b00, 1'b1, 1'b1); idle(6);
    // preempt landing in the last ACK cycle
    cyc(1'b1, 2'b01, 1'b0, 1'b0); idle(7);
    send_frame(2'b11); send_frame(2'b10); idle(12);
    send_frame(2'b11); idle(9);
    cyc(1'b0, 2'b00, 1'b1, 1'b0); idle(6);
    // ignored inputs: grant in REQ_TX, code 01 and preempt in WAIT_GRANT, req in COMM
    send_frame(2'b11); cyc(1'b1, 2'b10, 1'b0, 1'b0); idle(7);
    send_frame(2'b01); send_frame(2'b10); idle(6);
    send_frame(2'b11); idle(8);
    cyc(1'b1, 2'b01, 1'b0, 1'b0); idle(3);
    cyc(1'b0, 2'b00, 1'b1, 1'b0); idle(6);
    // reset while the request frame is on the line, then a full restart
    cyc(1'b1, 2'b11, 1'b0, 1'b0); idle(3);
    reset_mid();
    cyc(1'b1, 2'b01, 1'b0, 1'b0); idle(7);
    send_frame(2'b11); idle(9);
    cyc(1'b0, 2'b00, 1'b1, 1'b0); idle(6);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (rx_q.size() == 0 && $urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 7))
          0:       send_frame(2'b00);
          1:       send_frame(2'b01);
          2, 3:    send_frame(2'b10);
          default: send_frame(2'b11);
        endcase
      end
      cyc($urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)),
          $urandom_range(0, 7) == 0, $urandom_range(0, 11) == 0);
    end
    idle(4);
    @(negedge clk);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
